// File: rtl/ff_d_checker_pkg.sv
// Shared types and helpers for the D flip-flop response checker.
package ff_d_checker_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } chk_state_t;

    // Golden next-state of a D flip-flop with synchronous clear/preset; clear wins.
    function automatic logic dff_next(input logic preset, input logic clr, input logic d);
        if (clr) begin
            return 1'b0;
        end else if (preset) begin
            return 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/ff_d_checker_ref_model.sv
// Golden 1-bit register tracking what the flip-flop under test should hold.
module ff_d_ref_model
    import ff_d_checker_pkg::*;
(
    input  logic clk,
    input  logic clear,
    input  logic en,
    input  logic preset,
    input  logic clr_in,
    input  logic d,
    output logic exp_q
);

    // Update the model only on accepted vectors; state carries across vectors.
    always_ff @(posedge clk) begin
        if (clear) begin
            exp_q <= 1'b0;
        end else if (en) begin
            exp_q <= dff_next(preset, clr_in, d);
        end
    end

endmodule

// File: rtl/ff_d_checker.sv
// Response checker for a D flip-flop stimulus stream.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start; stimulus and DUT inputs ignored
//   S_RUN   | accepting vectors, comparing the previous one each cycle
//   S_FLUSH | last vector accepted; performing its compare
//   S_DONE  | results held until start or clear
module ff_d_checker
    import ff_d_checker_pkg::*;
#(
    parameter int NUM_VEC = 8,
    parameter int IDX_W   = 8,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             obs_valid,
    input  logic             obs_preset,
    input  logic             obs_clear,
    input  logic             obs_d,
    input  logic             dut_q,
    input  logic             dut_qnot,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err_idx,
    output logic [IDX_W-1:0] vec_idx
);

    localparam logic [IDX_W-1:0] NONE_IDX = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    chk_state_t       state;
    chk_state_t       state_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             exp_q;
    logic             cmp_pend;
    logic [IDX_W-1:0] cmp_idx;
    logic             accept;
    logic             start_run;
    logic             cmp_fail;
    logic [ERR_W-1:0] err_inc;
    logic [ERR_W-1:0] err_after_cmp;

    assign accept        = (state == S_RUN) && obs_valid;
    assign start_run     = start && ((state == S_IDLE) || (state == S_DONE));
    assign cmp_fail      = cmp_pend && ((dut_q != exp_q) || (dut_qnot != ~exp_q));
    assign err_inc       = (err_count == {ERR_W{1'b1}}) ? err_count : err_count + ERR_W'(1);
    assign err_after_cmp = cmp_fail ? err_inc : err_count;

    ff_d_ref_model u_ref (
        .clk    (clk),
        .clear  (clear),
        .en     (accept),
        .preset (obs_preset),
        .clr_in (obs_clear),
        .d      (obs_d),
        .exp_q  (exp_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (accept && (vec_idx == LAST_IDX)) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status flags decoded from the upcoming state so they can be registered.
    always_comb begin
        busy_nxt = (state_nxt == S_RUN) || (state_nxt == S_FLUSH);
        done_nxt = (state_nxt == S_DONE);
    end

    // Counters, compare bookkeeping and registered status outputs.
    always_ff @(posedge clk) begin
        if (clear) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= NONE_IDX;
            vec_idx       <= '0;
            cmp_pend      <= 1'b0;
            cmp_idx       <= '0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            if (start_run) begin
                pass          <= 1'b0;
                err_count     <= '0;
                first_err_idx <= NONE_IDX;
                vec_idx       <= '0;
                cmp_pend      <= 1'b0;
            end else begin
                cmp_pend <= accept;
                if (accept) begin
                    cmp_idx <= vec_idx;
                    vec_idx <= vec_idx + IDX_W'(1);
                end
                if (cmp_fail) begin
                    err_count <= err_inc;
                    if (first_err_idx == NONE_IDX) begin
                        first_err_idx <= cmp_idx;
                    end
                end
                // Verdict must include the final compare happening this same edge.
                if (state == S_FLUSH) begin
                    pass <= (err_after_cmp == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_ff_d_checker.sv
// Directed self-checking bench for ff_d_checker.
module tb_ff_d_checker;

    logic       clk = 1'b0;
    logic       clear, start, obs_valid, obs_preset, obs_clear, obs_d, dut_q, dut_qnot;
    logic       busy, done, pass;
    logic [7:0] err_count, first_err_idx, vec_idx;
    logic       busy2, done2, pass2;
    logic [1:0] err_count2;
    logic [7:0] first_err_idx2, vec_idx2;

    int n_cmp = 0;
    int n_err = 0;

    // Expected q after vectors {preset,clear,d} = 000..111, bit i = vector i.
    logic [7:0] exp_tbl;

    always #5 clk = ~clk;

    ff_d_checker #(.NUM_VEC(8), .IDX_W(8), .ERR_W(8)) dut (
        .clk(clk), .clear(clear), .start(start), .obs_valid(obs_valid),
        .obs_preset(obs_preset), .obs_clear(obs_clear), .obs_d(obs_d),
        .dut_q(dut_q), .dut_qnot(dut_qnot), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx), .vec_idx(vec_idx)
    );

    ff_d_checker #(.NUM_VEC(8), .IDX_W(8), .ERR_W(2)) dut2 (
        .clk(clk), .clear(clear), .start(start), .obs_valid(obs_valid),
        .obs_preset(obs_preset), .obs_clear(obs_clear), .obs_d(obs_d),
        .dut_q(dut_q), .dut_qnot(dut_qnot), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err_count2), .first_err_idx(first_err_idx2), .vec_idx(vec_idx2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Feed n vectors 000.. plus one trailing cycle for the last compare.
    // DUT response for vector i is presented in the cycle after it is offered.
    task automatic run_vectors(input int n, input logic [7:0] zmask, input bit qeq, input int start_at);
        logic q;
        for (int i = 0; i <= n; i++) begin
            obs_valid = (i < n);
            {obs_preset, obs_clear, obs_d} = i[2:0];
            q = 1'b0;
            if (i > 0) begin
                q = exp_tbl[i-1];
                if (zmask[i-1]) q = 1'b0;
            end
            dut_q    = q;
            dut_qnot = qeq ? q : ~q;
            start    = (i == start_at);
            step();
        end
        obs_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_pass"},  32'(pass), 32'd0);
        check({tag, "_err"},   32'(err_count), 32'd0);
        check({tag, "_first"}, 32'(first_err_idx), 32'hFF);
        check({tag, "_vidx"},  32'(vec_idx), 32'd0);
    endtask

    initial begin
        exp_tbl    = 8'b0011_0010;
        clear      = 1'b1;
        start      = 1'b0;
        obs_valid  = 1'b0;
        obs_preset = 1'b0;
        obs_clear  = 1'b0;
        obs_d      = 1'b0;
        dut_q      = 1'b0;
        dut_qnot   = 1'b1;

        // 1: reset values
        step();
        step();
        clear = 1'b0;
        check_reset_vals("rst");
        check("rst_err2", 32'(err_count2), 32'd0);

        // IDLE ignores stimulus and DUT
        obs_valid = 1'b1;
        dut_q     = 1'b1;
        dut_qnot  = 1'b1;
        step();
        step();
        obs_valid = 1'b0;
        check_reset_vals("idle");

        // 2: clean run
        pulse_start();
        check("t2_busy_run", 32'(busy), 32'd1);
        run_vectors(8, 8'h00, 1'b0, -1);
        check("t2_done",  32'(done), 32'd1);
        check("t2_pass",  32'(pass), 32'd1);
        check("t2_err",   32'(err_count), 32'd0);
        check("t2_vidx",  32'(vec_idx), 32'd8);
        check("t2_busy",  32'(busy), 32'd0);
        check("t2_first", 32'(first_err_idx), 32'hFF);

        // DONE ignores obs_valid
        obs_valid = 1'b1;
        step();
        step();
        obs_valid = 1'b0;
        check("done_hold_vidx", 32'(vec_idx), 32'd8);
        check("done_hold_done", 32'(done), 32'd1);

        // 3: q wrong on vector 4
        pulse_start();
        run_vectors(8, 8'h10, 1'b0, -1);
        check("t3_err",   32'(err_count), 32'd1);
        check("t3_first", 32'(first_err_idx), 32'd4);
        check("t3_pass",  32'(pass), 32'd0);
        check("t3_done",  32'(done), 32'd1);

        // 4: qnot == q, every vector fails
        pulse_start();
        run_vectors(8, 8'h00, 1'b1, -1);
        check("t4_err",   32'(err_count), 32'd8);
        check("t4_first", 32'(first_err_idx), 32'd0);
        check("t4_pass",  32'(pass), 32'd0);

        // 5: clear mid-run, then a fresh clean run
        pulse_start();
        run_vectors(4, 8'h00, 1'b1, -1);
        check("t5_mid_vidx", 32'(vec_idx), 32'd4);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_reset_vals("t5_clr");
        pulse_start();
        run_vectors(8, 8'h00, 1'b0, -1);
        check("t5_pass", 32'(pass), 32'd1);
        check("t5_done", 32'(done), 32'd1);
        check("t5_err",  32'(err_count), 32'd0);

        // 6: saturation, start ignored while busy, restart from DONE
        pulse_start();
        run_vectors(8, 8'h00, 1'b1, 3);
        check("t6_err2_sat", 32'(err_count2), 32'd3);
        check("t6_err8",     32'(err_count), 32'd8);
        check("t6_vidx",     32'(vec_idx), 32'd8);
        check("t6_done",     32'(done), 32'd1);
        check("t6_first2",   32'(first_err_idx2), 32'd0);
        pulse_start();
        check("t6_re_vidx",  32'(vec_idx), 32'd0);
        check("t6_re_err",   32'(err_count), 32'd0);
        check("t6_re_err2",  32'(err_count2), 32'd0);
        check("t6_re_first", 32'(first_err_idx), 32'hFF);
        check("t6_re_busy",  32'(busy), 32'd1);
        check("t6_re_done",  32'(done), 32'd0);
        check("t6_re_pass",  32'(pass), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
